// File: rtl/cdc_pkg.sv
// Shared constants for the clock-domain-crossing blocks.
package cdc_pkg;

    // Default depth of every synchronizer chain in the CDC blocks.
    localparam int CDC_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// N-flop single-bit synchronizer with asynchronous active-low reset.
module cdc_sync_bit
    import cdc_pkg::*;
#(
    parameter int   STAGES    = CDC_SYNC_STAGES_DEFAULT,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* async_reg = "true" *) logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the chain; the last stage is safe to use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_b2a.sv
// Toggle-handshake channel carrying multi-bit words from the clkb domain into clka.
// The source hold register is frozen while a request is in flight, so the
// destination can sample it directly once the synchronized request arrives.
module cdc_handshake_b2a
    import cdc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = CDC_SYNC_STAGES_DEFAULT
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              clkb,
    input  logic              rstb,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_valid,
    output logic              b_ready,
    output logic [DATA_W-1:0] a_data,
    output logic              a_valid,
    input  logic              a_ready
);

    // hold_q feeds a_data across the domain boundary; that path is covered by a
    // max-delay / false-path constraint, and keep stops it being optimised away.
    (* keep = "true" *) logic [DATA_W-1:0] hold_q;
    logic req_tgl_b;
    logic ack_sync_b;

    logic req_sync_a;
    logic req_seen_a;
    logic ack_tgl_a;
    logic pending_a;

    // ------------------------------------------------------------------
    // Source side (clkb)
    // ------------------------------------------------------------------

    cdc_sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_ack_sync (
        .clk   (clkb),
        .rst_n (rstb),
        .d     (ack_tgl_a),
        .q     (ack_sync_b)
    );

    assign b_ready = (req_tgl_b == ack_sync_b);

    // Capture a word and flip the request toggle when the channel is idle.
    always_ff @(posedge clkb or negedge rstb) begin
        if (!rstb) begin
            hold_q    <= '0;
            req_tgl_b <= 1'b0;
        end else if (b_valid && b_ready) begin
            hold_q    <= b_data;
            req_tgl_b <= ~req_tgl_b;
        end
    end

    // ------------------------------------------------------------------
    // Destination side (clka)
    // ------------------------------------------------------------------

    cdc_sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_req_sync (
        .clk   (clka),
        .rst_n (rsta),
        .d     (req_tgl_b),
        .q     (req_sync_a)
    );

    assign pending_a = (req_sync_a != req_seen_a);

    // Present a newly arrived word, and acknowledge it once the consumer takes it.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            req_seen_a <= 1'b0;
            a_valid    <= 1'b0;
            a_data     <= '0;
            ack_tgl_a  <= 1'b0;
        end else if (a_valid && a_ready) begin
            a_valid   <= 1'b0;
            ack_tgl_a <= ~ack_tgl_a;
        end else if (!a_valid && pending_a) begin
            a_data     <= hold_q;
            a_valid    <= 1'b1;
            req_seen_a <= req_sync_a;
        end
    end

endmodule

// File: tb/tb_cdc_handshake_b2a.sv
// Self-checking bench for the clkb-to-clka handshake channel.
`timescale 1ns/1ps
module tb_cdc_handshake_b2a;

    logic       clka    = 1'b0;
    logic       clkb    = 1'b0;
    logic       rsta    = 1'b0;
    logic       rstb    = 1'b0;
    logic [7:0] b_data  = 8'h00;
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready = 1'b0;

    realtime half_a = 5.0;
    realtime half_b = 13.5;

    int checks     = 0;
    int failures   = 0;
    int clka_edges = 0;
    int clkb_edges = 0;
    int acc_snap   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    cdc_handshake_b2a #(
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clka    (clka),
        .rsta    (rsta),
        .clkb    (clkb),
        .rstb    (rstb),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_ready (a_ready)
    );

    // Free-running clocks; half periods may be changed between phases.
    always #(half_a) clka = ~clka;
    always #(half_b) clkb = ~clkb;

    // Edge counters used for latency measurement across domains.
    always @(posedge clka) clka_edges <= clka_edges + 1;
    always @(posedge clkb) clkb_edges <= clkb_edges + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Record every word the source side accepts.
    always @(negedge clkb) begin
        if (rstb && b_valid && b_ready) exp_q.push_back(b_data);
    end

    // Compare every delivered word with the oldest accepted one.
    always @(negedge clka) begin
        if (rsta && a_valid && a_ready) begin
            got_q.push_back(a_data);
            checkOutput("sb_word_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) checkOutput("sb_order", 32'(a_data), 32'(exp_q.pop_front()));
        end
    end

    // Resetting the source alone while the destination runs is not a legal use.
    always @(negedge rstb) begin
        checkOutput("rstb_alone_illegal", 32'(rsta), 0);
    end

    // Offer one word on the source side and hold it until accepted.
    task automatic applyStimulus(input logic [7:0] data);
        int n;
        @(posedge clkb);
        #1;
        b_valid = 1'b1;
        b_data  = data;
        n = 0;
        do begin
            @(negedge clkb);
            n++;
        end while (!b_ready && n < 400);
        if (!b_ready) begin
            checkOutput("send_timeout", 32'(b_ready), 1);
            b_valid = 1'b0;
            return;
        end
        @(posedge clkb);
        acc_snap = clka_edges;
        #1;
        b_valid = 1'b0;
    endtask

    task automatic waitAValid(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clka);
            n++;
        end while (!a_valid && n < limit);
    endtask

    task automatic waitBReady(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clkb);
            n++;
        end while (!b_ready && n < limit);
    endtask

    task automatic waitGot(input int target, input int limit);
        int n;
        n = 0;
        while (got_q.size() < target && n < limit) begin
            @(negedge clka);
            n++;
        end
    endtask

    // Random traffic with random consumer back-pressure at a given clock ratio.
    task automatic runRandom(input realtime ha, input realtime hb, input int words);
        int base;
        int n;
        half_a = ha;
        half_b = hb;
        repeat (4) @(posedge clkb);
        base = got_q.size();
        fork
            begin
                for (int i = 0; i < words; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clkb);
                        #1;
                        b_data = 8'($urandom);
                    end
                    applyStimulus(8'($urandom));
                end
            end
            begin
                n = 0;
                while (got_q.size() < base + words && n < 20000) begin
                    @(posedge clka);
                    #1;
                    a_ready = 1'($urandom_range(0, 1));
                    n++;
                end
            end
        join
        @(posedge clka);
        #1;
        a_ready = 1'b1;
        repeat (20) @(negedge clka);
        checkOutput("rand_count", 32'(got_q.size() - base), 32'(words));
        checkOutput("rand_drained", 32'(exp_q.size()), 0);
        checkOutput("rand_b_ready_idle", 32'(b_ready), 1);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int lat;
        int snap_b;
        int spurious;
        int n;

        // Both resets held, then released together.
        repeat (6) @(posedge clkb);
        @(negedge clka);
        rsta = 1'b1;
        rstb = 1'b1;
        #1;
        checkOutput("reset_b_ready", 32'(b_ready), 1);
        checkOutput("reset_a_valid", 32'(a_valid), 0);
        checkOutput("reset_a_data", 32'(a_data), 0);
        spurious = 0;
        repeat (20) begin
            @(negedge clka);
            if (a_valid) spurious++;
        end
        checkOutput("reset_no_spurious", 32'(spurious), 0);

        // Single word, consumer always ready; measure both latencies.
        @(posedge clka);
        #1;
        a_ready = 1'b1;
        applyStimulus(8'hA5);
        waitAValid(50);
        checkOutput("a5_valid", 32'(a_valid), 1);
        lat = clka_edges - acc_snap;
        checkOutput("a5_latency_3to4", 32'(lat >= 3 && lat <= 4), 1);
        checkOutput("a5_data", 32'(a_data), 32'hA5);
        checkOutput("a5_busy", 32'(b_ready), 0);
        @(posedge clka);
        snap_b = clkb_edges;
        @(negedge clka);
        checkOutput("a5_one_cycle", 32'(a_valid), 0);
        waitBReady(50);
        lat = clkb_edges - snap_b;
        checkOutput("a5_ready_back", 32'(b_ready), 1);
        checkOutput("a5_ready_lat_2to3", 32'(lat >= 2 && lat <= 3), 1);

        // Back-pressure: 0x3C held while 0x11 waits on the source side.
        @(posedge clka);
        #1;
        a_ready = 1'b0;
        base = got_q.size();
        applyStimulus(8'h3C);
        fork
            applyStimulus(8'h11);
            begin
                waitAValid(50);
                repeat (10) @(negedge clka);
                checkOutput("bp_valid_held", 32'(a_valid), 1);
                checkOutput("bp_data_held", 32'(a_data), 32'h3C);
                checkOutput("bp_b_ready_low", 32'(b_ready), 0);
                checkOutput("bp_11_not_taken", 32'(exp_q.size()), 1);
                @(posedge clka);
                #1;
                a_ready = 1'b1;
            end
        join
        waitGot(base + 2, 300);
        checkOutput("bp_count", 32'(got_q.size() - base), 2);
        if (got_q.size() >= base + 2) begin
            checkOutput("bp_first", 32'(got_q[base]), 32'h3C);
            checkOutput("bp_second", 32'(got_q[base + 1]), 32'h11);
        end

        // b_data scrambled every clkb cycle while the word is in flight.
        base = got_q.size();
        applyStimulus(8'h5A);
        n = 0;
        while (!b_ready && n < 400) begin
            @(posedge clkb);
            #1;
            b_data = 8'($urandom);
            n++;
        end
        checkOutput("scr_ready_back", 32'(b_ready), 1);
        waitGot(base + 1, 100);
        checkOutput("scr_count", 32'(got_q.size() - base), 1);
        if (got_q.size() > base) checkOutput("scr_data", 32'(got_q[base]), 32'h5A);

        // Destination reset alone while 0x77 is in flight.
        repeat (5) @(negedge clka);
        base = got_q.size();
        applyStimulus(8'h77);
        rsta = 1'b0;
        repeat (5) @(posedge clka);
        @(negedge clka);
        checkOutput("rsta_valid_low", 32'(a_valid), 0);
        checkOutput("rsta_data_clear", 32'(a_data), 0);
        rsta = 1'b1;
        waitGot(base + 1, 100);
        checkOutput("rsta_delivered", 32'(got_q.size() - base), 1);
        if (got_q.size() > base) checkOutput("rsta_data", 32'(got_q[base]), 32'h77);
        waitBReady(100);
        checkOutput("rsta_ready_back", 32'(b_ready), 1);
        repeat (30) @(negedge clka);
        checkOutput("rsta_exactly_once", 32'(got_q.size() - base), 1);

        // 1000 random words over three clock ratios.
        runRandom(5.0, 14.9, 334);
        runRandom(14.9, 5.0, 333);
        runRandom(5.0, 5.35, 333);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
